// File: rtl/keycode_event_fifo_if.sv
// Handshake bundle for keycode_event_fifo: report input channel and event
// output channel. The host/consumer side uses master, the block uses slave.
interface keycode_event_fifo_if #(
  parameter int SLOTS = 4,
  parameter int KEY_W = 8
);
  logic [SLOTS*KEY_W-1:0] report_data;
  logic                   report_valid;
  logic                   report_ready;
  logic                   evt_valid;
  logic                   evt_ready;
  logic [KEY_W-1:0]       evt_code;
  logic                   evt_press;

  modport master (
    output report_data, report_valid, evt_ready,
    input  report_ready, evt_valid, evt_code, evt_press
  );

  modport slave (
    input  report_data, report_valid, evt_ready,
    output report_ready, evt_valid, evt_code, evt_press
  );
endinterface

// File: rtl/keycode_event_fifo.sv
// USB HID keycode event generator. Each accepted report is diffed against the
// previously committed report; releases are queued first (ascending slot),
// then presses, into a first-word-fall-through event FIFO. Reports carrying
// the rollover error code are dropped. The scan stalls while the FIFO is full
// so no event is ever lost.
module keycode_event_fifo #(
  parameter int               SLOTS    = 4,
  parameter int               KEY_W    = 8,
  parameter int               DEPTH    = 8,
  parameter logic [KEY_W-1:0] ERR_CODE = KEY_W'(1)
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  keycode_event_fifo_if.slave        bus,
  input  logic                       clr_flags,
  output logic [$clog2(SLOTS+1)-1:0] held_count,
  output logic                       overrun
);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(SLOTS+1);

  typedef enum logic [1:0] {IDLE, SCAN_REL, SCAN_PRS, COMMIT} state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [KEY_W-1:0]       prev_reg [SLOTS];
  logic [KEY_W-1:0]       cur_reg  [SLOTS];
  logic [HC_W-1:0]        held_reg;
  logic                   overrun_reg;

  logic [KEY_W-1:0]       mem_code  [DEPTH];
  logic                   mem_press [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;

  logic [KEY_W-1:0]       in_slot [SLOTS];
  logic [SLOTS-1:0]       err_hit;
  logic                   report_err;
  logic                   rel_need;
  logic                   prs_need;
  logic                   need_evt;
  logic                   scanning;
  logic                   last_slot;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   advance;
  logic [KEY_W-1:0]       push_code;
  logic                   push_press;
  logic [HC_W-1:0]        cur_distinct;
  logic                   uniq;

  // Split the incoming report into slots and flag rollover errors.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign in_slot[gi] = bus.report_data[gi*KEY_W +: KEY_W];
      assign err_hit[gi] = (in_slot[gi] == ERR_CODE);
    end
  endgenerate
  assign report_err = |err_hit;

  // Decide whether the slot under scan produces a release or press event.
  always_comb begin
    rel_need = (prev_reg[idx_reg] != '0);
    prs_need = (cur_reg[idx_reg] != '0);
    for (int j = 0; j < SLOTS; j++) begin
      if (cur_reg[j] == prev_reg[idx_reg]) rel_need = 1'b0;
      if (prev_reg[j] == cur_reg[idx_reg]) prs_need = 1'b0;
      if (IDX_W'(j) < idx_reg) begin
        if (prev_reg[j] == prev_reg[idx_reg]) rel_need = 1'b0;
        if (cur_reg[j] == cur_reg[idx_reg])   prs_need = 1'b0;
      end
    end
  end

  // Count distinct non-zero codes in the report about to be committed.
  always_comb begin
    cur_distinct = '0;
    uniq         = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      uniq = (cur_reg[i] != '0);
      for (int j = 0; j < i; j++) begin
        if (cur_reg[j] == cur_reg[i]) uniq = 1'b0;
      end
      if (uniq) cur_distinct = cur_distinct + 1'b1;
    end
  end

  assign scanning   = (state_reg == SCAN_REL) || (state_reg == SCAN_PRS);
  assign need_evt   = (state_reg == SCAN_REL) ? rel_need :
                      (state_reg == SCAN_PRS) ? prs_need : 1'b0;
  assign push_code  = (state_reg == SCAN_REL) ? prev_reg[idx_reg] : cur_reg[idx_reg];
  assign push_press = (state_reg == SCAN_PRS);
  assign last_slot  = (idx_reg == IDX_W'(SLOTS-1));
  // Fullness is judged before this cycle's pop, so a full FIFO never accepts.
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign push       = need_evt && !full;
  assign advance    = scanning && (!need_evt || !full);
  assign pop        = (count_reg != '0) && bus.evt_ready;

  // Scan FSM: accept, walk releases, walk presses, commit.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      held_reg  <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        prev_reg[i] <= '0;
        cur_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.report_valid && !report_err) begin
            for (int i = 0; i < SLOTS; i++) cur_reg[i] <= in_slot[i];
            idx_reg   <= '0;
            state_reg <= SCAN_REL;
          end
        end
        SCAN_REL: begin
          if (advance) begin
            if (last_slot) begin
              idx_reg   <= '0;
              state_reg <= SCAN_PRS;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        SCAN_PRS: begin
          if (advance) begin
            if (last_slot) begin
              idx_reg   <= '0;
              state_reg <= COMMIT;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          for (int i = 0; i < SLOTS; i++) prev_reg[i] <= cur_reg[i];
          held_reg  <= cur_distinct;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_code[i]  <= '0;
        mem_press[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_code[wr_ptr_reg]  <= push_code;
        mem_press[wr_ptr_reg] <= push_press;
        wr_ptr_reg            <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      overrun_reg <= 1'b0;
    end else if (bus.report_valid && !bus.report_ready) begin
      overrun_reg <= 1'b1;
    end else if (clr_flags) begin
      overrun_reg <= 1'b0;
    end
  end

  assign bus.report_ready = (state_reg == IDLE) && !reset_reset;
  assign bus.evt_valid    = (count_reg != '0);
  assign bus.evt_code     = mem_code[rd_ptr_reg];
  assign bus.evt_press    = mem_press[rd_ptr_reg];
  assign held_count       = held_reg;
  assign overrun          = overrun_reg;
endmodule

// File: tb/tb_keycode_event_fifo.sv
// Directed bench for keycode_event_fifo (SLOTS=4, KEY_W=8, DEPTH=2).
// Popped events are logged as {press, code} and compared with hand-derived
// sequences; each transaction prints one line.
module tb_keycode_event_fifo;
  logic       clk;
  logic       reset_reset;
  logic       clr_flags;
  logic [2:0] held_count;
  logic       overrun;
  logic [8:0] evq [$];
  int         tests = 0;
  int         fails = 0;
  int         lat;

  keycode_event_fifo_if #(.SLOTS(4), .KEY_W(8)) bus ();

  keycode_event_fifo #(.SLOTS(4), .KEY_W(8), .DEPTH(2), .ERR_CODE(8'h01)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .bus         (bus.slave),
    .clr_flags   (clr_flags),
    .held_count  (held_count),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every event handed to the consumer.
  always @(posedge clk) begin
    if (!reset_reset && bus.evt_valid && bus.evt_ready) begin
      evq.push_back({bus.evt_press, bus.evt_code});
      $display("[TB] event code=%02h press=%0b", bus.evt_code, bus.evt_press);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ev(input int i);
    if (i < evq.size()) return evq[i];
    return 9'h1FF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one report, then count cycles until report_ready returns.
  task automatic send_report(input logic [31:0] data, output int cycles);
    int n;
    n = 0;
    while (!bus.report_ready && n < 200) begin
      tick(1);
      n++;
    end
    bus.report_data  = data;
    bus.report_valid = 1'b1;
    tick(1);
    bus.report_valid = 1'b0;
    cycles = 1;
    while (!bus.report_ready && cycles < 200) begin
      tick(1);
      cycles++;
    end
    $display("[TB] report %08h done after %0d cycles", data, cycles);
  endtask

  initial begin
    reset_reset      = 1'b1;
    clr_flags        = 1'b0;
    bus.report_data  = '0;
    bus.report_valid = 1'b0;
    bus.evt_ready    = 1'b1;
    tick(3);
    check("ready_in_reset", 32'(bus.report_ready), 0);
    reset_reset = 1'b0;
    tick(1);
    check("rst_ready",   32'(bus.report_ready), 1);
    check("rst_evalid",  32'(bus.evt_valid), 0);
    check("rst_ecode",   32'(bus.evt_code), 0);
    check("rst_epress",  32'(bus.evt_press), 0);
    check("rst_held",    32'(held_count), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Single new key in slot 0.
    evq.delete();
    send_report(32'h00000004, lat);
    check("lat_first", lat, 10);
    check("held_1", 32'(held_count), 1);
    tick(3);
    check("n_first", evq.size(), 1);
    check("ev_first", 32'(ev(0)), 32'h104);

    // Add 0x05 in slot 3: only its press.
    evq.delete();
    send_report(32'h05000004, lat);
    tick(3);
    check("n_add", evq.size(), 1);
    check("ev_add", 32'(ev(0)), 32'h105);
    check("held_2", 32'(held_count), 2);

    // All released, ascending slot order.
    evq.delete();
    send_report(32'h00000000, lat);
    tick(3);
    check("n_rel", evq.size(), 2);
    check("ev_rel0", 32'(ev(0)), 32'h004);
    check("ev_rel1", 32'(ev(1)), 32'h005);
    check("held_0", 32'(held_count), 0);

    // Rollover error report is dropped.
    evq.delete();
    send_report(32'h01040600, lat);
    check("lat_drop", lat, 1);
    tick(3);
    check("n_drop", evq.size(), 0);
    check("held_drop", 32'(held_count), 0);
    check("ready_drop", 32'(bus.report_ready), 1);

    // Duplicate key across slots yields a single press.
    evq.delete();
    send_report(32'h04040000, lat);
    check("lat_dup", lat, 10);
    tick(3);
    check("n_dup", evq.size(), 1);
    check("ev_dup", 32'(ev(0)), 32'h104);
    check("held_dup", 32'(held_count), 1);

    // FIFO full stalls the scan; overrun flag behaviour during the stall.
    evq.delete();
    bus.evt_ready    = 1'b0;
    bus.report_data  = 32'h0D0C0B0A;
    bus.report_valid = 1'b1;
    tick(1);
    bus.report_valid = 1'b0;
    tick(8);
    check("stall_ready",  32'(bus.report_ready), 0);
    check("stall_evalid", 32'(bus.evt_valid), 1);
    check("stall_head",   32'({bus.evt_press, bus.evt_code}), 32'h004);
    check("ovr_before",   32'(overrun), 0);
    bus.report_valid = 1'b1;
    tick(1);
    bus.report_valid = 1'b0;
    check("ovr_set", 32'(overrun), 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    check("ovr_clr", 32'(overrun), 0);
    bus.report_valid = 1'b1;
    clr_flags        = 1'b1;
    tick(1);
    bus.report_valid = 1'b0;
    clr_flags        = 1'b0;
    check("ovr_set_wins", 32'(overrun), 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    $display("[TB] stall released");
    bus.evt_ready = 1'b1;
    lat = 0;
    while (!bus.report_ready && lat < 200) begin
      tick(1);
      lat++;
    end
    check("stall_done", 32'(bus.report_ready), 1);
    tick(3);
    check("n_stall", evq.size(), 5);
    check("ev_st0", 32'(ev(0)), 32'h004);
    check("ev_st1", 32'(ev(1)), 32'h10A);
    check("ev_st2", 32'(ev(2)), 32'h10B);
    check("ev_st3", 32'(ev(3)), 32'h10C);
    check("ev_st4", 32'(ev(4)), 32'h10D);
    check("held_4", 32'(held_count), 4);
    check("drained", 32'(bus.evt_valid), 0);

    // Reset asserted during the press scan.
    bus.report_data  = 32'h00000004;
    bus.report_valid = 1'b1;
    tick(1);
    bus.report_valid = 1'b0;
    tick(4);
    reset_reset = 1'b1;
    tick(1);
    check("midrst_evalid", 32'(bus.evt_valid), 0);
    check("midrst_ready",  32'(bus.report_ready), 0);
    check("midrst_held",   32'(held_count), 0);
    reset_reset = 1'b0;
    tick(1);
    $display("[TB] reset released after mid-scan abort");
    evq.delete();
    send_report(32'h00000004, lat);
    check("lat_after_rst", lat, 10);
    tick(3);
    check("n_after_rst", evq.size(), 1);
    check("ev_after_rst", 32'(ev(0)), 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
